mat_serialize: RTL
==================

Name: mat_serialize

Overview:
Sink side of the matrix stb/ack interface driven by mat_mul_scalar and other linalg units.
- Accepts one packed M x N matrix of WIDTH-bit words (IEEE-754 single by default) in a single handshake.
- Emits the elements one per handshake on an element stream, tagged with row/column index and a last flag.
- Feeds element-serial consumers such as float adders, accumulators and output FIFOs.

Parameters:
M, 2, number of rows
N, 3, number of columns
WIDTH, 32, bits per element
COL_MAJOR, 0, 0 = emit row-major (column index fastest); 1 = column-major (row index fastest)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high
input_mat  in  [M-1:0][N-1:0][WIDTH-1:0]  matrix; element (i,j) = input_mat[i][j]
input_mat_stb  in  1  producer holds input_mat valid
input_mat_ack  out  1  block ready to capture a matrix (registered)
output_elem  out  WIDTH  current element
output_elem_row  out  RW = max($clog2(M),1)  row index of output_elem
output_elem_col  out  CW = max($clog2(N),1)  column index of output_elem
output_elem_last  out  1  high while the current element is the final one of the matrix
output_elem_stb  out  1  element outputs valid (registered)
output_elem_ack  in  1  consumer accepts element

Behaviour:
- Transfer rule: a transfer happens at a rising edge where stb && ack are both high. Holding ack high permanently is legal.
- Reset values while rst is high: input_mat_ack=0, output_elem_stb=0, output_elem=0, row=0, col=0, last=0, state=IDLE.
- First cycle after rst falls: input_mat_ack=1.
- Reset mid-stream: the matrix buffer and index are abandoned. The next edge with rst high forces the reset values.
- State IDLE:
  - input_mat_ack=1, output_elem_stb=0.
  - On an input transfer: copy all M*N elements into an internal buffer, set index to (0,0), input_mat_ack->0, output_elem_stb->1, go to EMIT.
  - Latency: the first element is valid in the cycle right after the capture edge.
- State EMIT:
  - input_mat_ack=0.
  - output_elem, row, col and last are driven from the buffer at the current index. They stay stable while stb=1 and ack=0.
  - On an output transfer when the element is not last: advance the index. Row-major increments col and wraps N-1->0 with row+1. Column-major increments row and wraps M-1->0 with col+1. stb stays 1.
  - On an output transfer when the element is last (index (M-1,N-1)): stb->0, index->(0,0), input_mat_ack->1, go to IDLE.
- Throughput with ack tied high: M*N element cycles plus 1 IDLE cycle per matrix.
- No overlap: a new matrix is never accepted while in EMIT.
- input_mat and input_mat_stb are ignored outside IDLE. Changes to input_mat after capture do not affect the output.
- M=1 or N=1: index widths clamp to 1 bit and the unused index stays 0. For M=N=1, last=1 on the only element.
- Data passes through bit-exactly; no arithmetic is performed.

Decomposition:
- Shared package linalg_pkg:
  - float32_t typedef (logic [31:0]).
  - Handshake state enum {IDLE, EMIT}, shared with the other linalg stream units.
  - Float constants used by benches: 1.0=0x3F800000, 2.0=0x40000000.
- One natural sub-module, mat_index_counter (parameters M, N, COL_MAJOR):
  - Inputs: clear, advance.
  - Outputs: row, col, last.
  - Reused later by a mat_deserialize block.

Test Plan:
1. COL_MAJOR=0, ack tied 1, input_mat={1.0,2.0,3.0,4.0,5.0,6.0} (MSB first), stb=1 -> elements 0x40C00000, 0x40A00000, 0x40800000, 0x40400000, 0x40000000, 0x3F800000 on consecutive cycles; last only on the 6th; input_mat_ack=1 on the following cycle.
2. COL_MAJOR=1, same matrix -> order 6.0, 3.0, 5.0, 2.0, 4.0, 1.0 with (row,col) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
3. Backpressure: output_elem_ack toggling 1,0,1,0 -> exactly 6 transfers, none dropped or duplicated; outputs constant during ack=0 cycles.
4. input_mat changed to {6.0..1.0} one cycle after capture -> the stream still equals scenario 1; the new matrix is emitted only after the next IDLE capture.
5. rst pulsed for 1 cycle after 3 transfers -> stb=0 and input_mat_ack=0 in the reset cycle, ack=1 the cycle after; the next matrix starts again at (0,0) with 0x40C00000.
6. Chained after mat_mul_scalar (M=2, N=3), scalar 2.0, scenario-1 matrix -> 0x41400000, 0x41200000, 0x41000000, 0x40C00000, 0x40800000, 0x40000000.

Source files
------------

// File: rtl/linalg_pkg.sv
// Shared types and constants for the linalg matrix stream units.
// Handshake state, float word type and index-width helper live here.
package linalg_pkg;

    typedef logic [31:0] float32_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } hs_state_t;

    localparam float32_t FLOAT_ONE = 32'h3F80_0000;
    localparam float32_t FLOAT_TWO = 32'h4000_0000;

    // Index widths never collapse to zero bits, even for a single row/column.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_index_counter.sv
// Row/column walker over an M x N matrix, row-major or column-major.
// Shared by the serializer and deserializer stream units.
module mat_index_counter
    import linalg_pkg::*;
#(
    parameter int M         = 2,
    parameter int N         = 3,
    parameter int COL_MAJOR = 0,
    localparam int RW       = idx_width(M),
    localparam int CW       = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(M - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(N - 1);

    logic [RW-1:0] row_reg, row_next;
    logic [CW-1:0] col_reg, col_next;
    logic          row_wrap;
    logic          col_wrap;

    assign row_wrap = (row_reg == ROW_MAX);
    assign col_wrap = (col_reg == COL_MAX);

    // The fast index wraps and carries into the slow one; a degenerate
    // dimension of size 1 always sits at its max and therefore stays 0.
    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (clear) begin
            row_next = '0;
            col_next = '0;
        end else if (advance) begin
            if (COL_MAJOR != 0) begin
                row_next = row_wrap ? '0 : row_reg + 1'b1;
                if (row_wrap) begin
                    col_next = col_wrap ? '0 : col_reg + 1'b1;
                end
            end else begin
                col_next = col_wrap ? '0 : col_reg + 1'b1;
                if (col_wrap) begin
                    row_next = row_wrap ? '0 : row_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    assign row  = row_reg;
    assign col  = col_reg;
    assign last = row_wrap && col_wrap;

endmodule

// File: rtl/mat_serialize.sv
// Captures a whole M x N matrix in one handshake and replays it as an
// element stream tagged with row/column index and a last flag.
module mat_serialize
    import linalg_pkg::*;
#(
    parameter int M         = 2,
    parameter int N         = 3,
    parameter int WIDTH     = 32,
    parameter int COL_MAJOR = 0,
    localparam int RW       = idx_width(M),
    localparam int CW       = idx_width(N)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [M-1:0][N-1:0][WIDTH-1:0] input_mat,
    input  logic                          input_mat_stb,
    output logic                          input_mat_ack,
    output logic [WIDTH-1:0]              output_elem,
    output logic [RW-1:0]                 output_elem_row,
    output logic [CW-1:0]                 output_elem_col,
    output logic                          output_elem_last,
    output logic                          output_elem_stb,
    input  logic                          output_elem_ack
);

    hs_state_t state_reg, state_next;
    logic      ack_reg, ack_next;
    logic      stb_reg, stb_next;
    logic      in_xfer, out_xfer;
    logic      idx_clear, idx_advance, idx_last;
    logic [RW-1:0] idx_row;
    logic [CW-1:0] idx_col;
    logic [M-1:0][N-1:0][WIDTH-1:0] buf_reg;

    assign in_xfer  = (state_reg == IDLE) && ack_reg && input_mat_stb;
    assign out_xfer = (state_reg == EMIT) && stb_reg && output_elem_ack;

    mat_index_counter #(
        .M         (M),
        .N         (N),
        .COL_MAJOR (COL_MAJOR)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .clear   (idx_clear),
        .advance (idx_advance),
        .row     (idx_row),
        .col     (idx_col),
        .last    (idx_last)
    );

    // The buffer is only loaded on capture, so the producer may change
    // input_mat freely while the stream is being emitted.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            buf_reg <= input_mat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            stb_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
            stb_reg   <= stb_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_xfer) state_next = EMIT;
            EMIT:    if (out_xfer && idx_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_next    = (state_next == IDLE);
        stb_next    = (state_next == EMIT);
        idx_clear   = in_xfer || (out_xfer && idx_last);
        idx_advance = out_xfer && !idx_last;
    end

    // Element data and last are masked outside EMIT so idle/reset outputs read zero.
    assign input_mat_ack    = ack_reg;
    assign output_elem_stb  = stb_reg;
    assign output_elem      = stb_reg ? buf_reg[idx_row][idx_col] : '0;
    assign output_elem_row  = idx_row;
    assign output_elem_col  = idx_col;
    assign output_elem_last = stb_reg && idx_last;

endmodule
